instr_fetch_unit: RTL and testbench

Fetch stage of the RISC-V core: owns the program counter and drives the byte address into the combinational instruction memory. It captures the returned word together with its PC into a small flushable buffer and hands instructions to the decoder over a valid/ready handshake. Redirects from jumps, branches, traps or `mret` reload the PC and discard every instruction already buffered.

---
 rtl/riscv_fetch_pkg.sv | 16 +
 rtl/fetch_buffer.sv | 79 +++++++
 rtl/instr_fetch_unit.sv | 113 +++++++++++
 tb/tb_instr_fetch_unit.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/riscv_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
//   FETCH_RESET_PC : default PC loaded by reset
//   IMEM_BYTES     : default instruction memory size in bytes
//   fetch_entry_t  : one fetch buffer entry {instr, pc, fault}
package riscv_fetch_pkg;

    localparam logic [31:0] FETCH_RESET_PC = 32'h0000_0000;
    localparam int unsigned IMEM_BYTES     = 4096;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        fault;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Synchronous flushable FIFO of fetch entries.
// Ports:
//   clk_i, rst_i  : clock, synchronous active-high reset (empties the FIFO)
//   flush_i       : discard all entries; wins over push and pop
//   push_i        : write entry_i; caller only pushes when not full or popping
//   entry_i       : entry to write
//   pop_i         : drop the head; caller only pops when not empty
//   head_o        : head entry, all zeros when empty
//   empty_o       : no entries held
//   full_o        : DEPTH entries held
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_buffer
    import riscv_fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         flush_i,
    input  logic         push_i,
    input  fetch_entry_t entry_i,
    input  logic         pop_i,
    output fetch_entry_t head_o,
    output logic         empty_o,
    output logic         full_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    fetch_entry_t    mem_q [DEPTH];
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0] count_q, count_d;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CntW'(DEPTH));
    assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) wr_ptr_d = wr_ptr_q + PtrW'(1);
            if (pop_i)  rd_ptr_d = rd_ptr_q + PtrW'(1);
            // Push+pop together (including on a full buffer) leaves count unchanged.
            unique case ({push_i, pop_i})
                2'b10:   count_d = count_q + CntW'(1);
                2'b01:   count_d = count_q - CntW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage needs no reset: count gates visibility of every slot.
    always_ff @(posedge clk_i) begin
        if (push_i && !flush_i) begin
            mem_q[wr_ptr_q] <= entry_i;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, addresses the combinational instruction memory,
// buffers {instr, pc, fault} and hands instructions to decode via valid/ready.
// A redirect reloads the PC and flushes every buffered instruction.
// Ports:
//   clk_i, rst_i                   : clock, synchronous active-high reset
//   imem_addr_o / imem_rdata_i     : instruction memory address / same-cycle word
//   redirect_i / redirect_pc_i     : load a new PC (unaligned targets allowed)
//   instr_o, instr_pc_o            : head instruction and its PC (0 when empty)
//   instr_valid_o / instr_ready_i  : decode handshake
//   fault_o                        : head entry is a fetch fault
// Optional feature, macro IFU_FAULT_CHECK_EN: flags misaligned or out-of-range
// fetches and halts fetching after pushing one until the next redirect.
// Without it fault_o is tied to 0 and fetch runs unchecked.
module instr_fetch_unit
    import riscv_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = FETCH_RESET_PC,
    parameter int unsigned IMEM_BYTES = riscv_fetch_pkg::IMEM_BYTES,
    parameter int unsigned BUF_DEPTH  = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_rdata_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic        fault_o
);

    logic [31:0]  pc_q, pc_d;
    logic         push, pop;
    logic         buf_empty, buf_full;
    logic         fetch_fault;
    fetch_entry_t wr_entry, head;

    assign imem_addr_o   = pc_q;
    assign instr_valid_o = !buf_empty;
    assign instr_o       = head.instr;
    assign instr_pc_o    = head.pc;
    assign pop           = instr_valid_o && instr_ready_i;

`ifdef IFU_FAULT_CHECK_EN
    localparam logic [31:0] ImemLast = 32'(IMEM_BYTES - 4);

    logic halted_q, halted_d;

    assign fetch_fault = (pc_q[1:0] != 2'b00) || (pc_q > ImemLast);
    assign push        = !redirect_i && !halted_q && (!buf_full || pop);
    assign fault_o     = instr_valid_o && head.fault;

    always_comb begin
        halted_d = halted_q;
        if (redirect_i) begin
            halted_d = 1'b0;
        end else if (push && fetch_fault) begin
            halted_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            halted_q <= 1'b0;
        end else begin
            halted_q <= halted_d;
        end
    end
`else
    logic unused_cfg;

    assign fetch_fault = 1'b0;
    assign push        = !redirect_i && (!buf_full || pop);
    assign fault_o     = 1'b0;
    assign unused_cfg  = ^{IMEM_BYTES, head.fault};
`endif

    assign wr_entry = '{instr: imem_rdata_i, pc: pc_q, fault: fetch_fault};

    always_comb begin
        pc_d = pc_q;
        if (redirect_i) begin
            pc_d = redirect_pc_i;
        end else if (push) begin
            pc_d = pc_q + 32'd4;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    fetch_buffer #(
        .DEPTH (BUF_DEPTH)
    ) u_fetch_buffer (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (redirect_i),
        .push_i  (push),
        .entry_i (wr_entry),
        .pop_i   (pop),
        .head_o  (head),
        .empty_o (buf_empty),
        .full_o  (buf_full)
    );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit (default parameters).
// Memory model: word i holds (i << 7) | 0x13 for byte addresses below 4096, else 0.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        fault;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a < 32'd4096) return ((a >> 2) << 7) | 32'h13;
        return 32'h0;
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    instr_fetch_unit dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .imem_addr_o   (imem_addr),
        .imem_rdata_i  (imem_rdata),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .instr_o       (instr),
        .instr_pc_o    (instr_pc),
        .instr_valid_o (instr_valid),
        .instr_ready_i (instr_ready),
        .fault_o       (fault)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; redirect = 1'b0; redirect_pc = 32'h0; instr_ready = 1'b1;
        tick(); tick();
        checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b want=0", instr_valid); end
        checks++; if (instr !== 32'h0) begin failures++; $display("FAIL reset_instr got=%h want=0", instr); end
        checks++; if (instr_pc !== 32'h0) begin failures++; $display("FAIL reset_instr_pc got=%h want=0", instr_pc); end
        checks++; if (fault !== 1'b0) begin failures++; $display("FAIL reset_fault got=%b want=0", fault); end
        checks++; if (imem_addr !== 32'h0) begin failures++; $display("FAIL reset_addr got=%h want=0", imem_addr); end
        rst = 1'b0;
        tick();
        checks++; if (instr_valid !== 1'b1) begin failures++; $display("FAIL first_valid got=%b want=1", instr_valid); end
        checks++; if (instr_pc !== 32'h0) begin failures++; $display("FAIL first_pc got=%h want=0", instr_pc); end
        checks++; if (instr !== 32'h13) begin failures++; $display("FAIL first_instr got=%h want=13", instr); end
        checks++; if (imem_addr !== 32'h4) begin failures++; $display("FAIL first_addr got=%h want=4", imem_addr); end
        tick();
        checks++; if (instr_pc !== 32'h4 || instr !== 32'h93) begin failures++; $display("FAIL stream_1 got=%h/%h want=4/93", instr_pc, instr); end
        tick();
        checks++; if (instr_pc !== 32'h8 || instr !== 32'h113) begin failures++; $display("FAIL stream_2 got=%h/%h want=8/113", instr_pc, instr); end
        tick();
        checks++; if (instr_pc !== 32'hC || instr !== 32'h193) begin failures++; $display("FAIL stream_3 got=%h/%h want=c/193", instr_pc, instr); end
    endtask

    task automatic test_stall();
        rst = 1'b1; instr_ready = 1'b0;
        tick();
        rst = 1'b0;
        repeat (5) tick();
        checks++; if (imem_addr !== 32'h8) begin failures++; $display("FAIL stall_addr got=%h want=8", imem_addr); end
        checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0) begin failures++; $display("FAIL stall_head got=%b/%h want=1/0", instr_valid, instr_pc); end
        instr_ready = 1'b1;
        tick();
        checks++; if (instr_pc !== 32'h4) begin failures++; $display("FAIL drain_1 got=%h want=4", instr_pc); end
        tick();
        checks++; if (instr_pc !== 32'h8) begin failures++; $display("FAIL drain_2 got=%h want=8", instr_pc); end
        tick();
        checks++; if (instr_pc !== 32'hC) begin failures++; $display("FAIL drain_3 got=%h want=c", instr_pc); end
        checks++; if (imem_addr !== 32'h14) begin failures++; $display("FAIL drain_addr got=%h want=14", imem_addr); end
    endtask

    task automatic test_redirect_full();
        instr_ready = 1'b0;
        tick(); tick();
        redirect = 1'b1; redirect_pc = 32'h40; instr_ready = 1'b1;
        tick();
        redirect = 1'b0;
        checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL redir_flush got=%b want=0", instr_valid); end
        checks++; if (imem_addr !== 32'h40) begin failures++; $display("FAIL redir_addr got=%h want=40", imem_addr); end
        checks++; if (instr_pc !== 32'h0 || instr !== 32'h0) begin failures++; $display("FAIL redir_empty_out got=%h/%h want=0/0", instr_pc, instr); end
        tick();
        checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h40 || instr !== 32'h813) begin failures++; $display("FAIL redir_target got=%b/%h/%h want=1/40/813", instr_valid, instr_pc, instr); end
        tick();
        checks++; if (instr_pc !== 32'h44 || instr !== 32'h893) begin failures++; $display("FAIL redir_next got=%h/%h want=44/893", instr_pc, instr); end
    endtask

    task automatic test_reset_midstream();
        rst = 1'b1; instr_ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h80;
        tick();
        rst = 1'b0; redirect = 1'b0;
        checks++; if (instr_valid !== 1'b0 || imem_addr !== 32'h0) begin failures++; $display("FAIL midreset got=%b/%h want=0/0", instr_valid, imem_addr); end
    endtask

`ifndef IFU_FAULT_CHECK_EN
    task automatic test_imem_edge();
        redirect = 1'b1; redirect_pc = 32'hFFC; instr_ready = 1'b1;
        tick();
        redirect = 1'b0;
        checks++; if (imem_addr !== 32'hFFC || instr_valid !== 1'b0) begin failures++; $display("FAIL edge_redir got=%h/%b want=ffc/0", imem_addr, instr_valid); end
        tick();
        checks++; if (instr_pc !== 32'hFFC || instr !== 32'h1FF93 || fault !== 1'b0) begin failures++; $display("FAIL edge_last got=%h/%h/%b want=ffc/1ff93/0", instr_pc, instr, fault); end
        tick();
        checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h1000 || instr !== 32'h0 || fault !== 1'b0) begin failures++; $display("FAIL edge_oob got=%b/%h/%h/%b want=1/1000/0/0", instr_valid, instr_pc, instr, fault); end
        tick();
        checks++; if (instr_pc !== 32'h1004) begin failures++; $display("FAIL edge_oob2 got=%h want=1004", instr_pc); end
    endtask

    task automatic test_pc_wrap();
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC; instr_ready = 1'b1;
        tick();
        redirect = 1'b0;
        tick();
        checks++; if (instr_pc !== 32'hFFFF_FFFC || imem_addr !== 32'h0) begin failures++; $display("FAIL wrap_top got=%h/%h want=fffffffc/0", instr_pc, imem_addr); end
        tick();
        checks++; if (instr_pc !== 32'h0 || instr !== 32'h13) begin failures++; $display("FAIL wrap_zero got=%h/%h want=0/13", instr_pc, instr); end
    endtask
`else
    task automatic test_fault_range();
        redirect = 1'b1; redirect_pc = 32'h1000; instr_ready = 1'b0;
        tick();
        redirect = 1'b0;
        tick();
        checks++; if (instr_valid !== 1'b1 || fault !== 1'b1 || instr_pc !== 32'h1000) begin failures++; $display("FAIL oob_fault got=%b/%b/%h want=1/1/1000", instr_valid, fault, instr_pc); end
        checks++; if (imem_addr !== 32'h1004) begin failures++; $display("FAIL oob_addr got=%h want=1004", imem_addr); end
        tick(); tick();
        checks++; if (imem_addr !== 32'h1004 || instr_pc !== 32'h1000) begin failures++; $display("FAIL oob_halt got=%h/%h want=1004/1000", imem_addr, instr_pc); end
        instr_ready = 1'b1;
        tick();
        checks++; if (instr_valid !== 1'b0 || fault !== 1'b0) begin failures++; $display("FAIL oob_nopush got=%b/%b want=0/0", instr_valid, fault); end
        redirect = 1'b1; redirect_pc = 32'h8;
        tick();
        redirect = 1'b0;
        tick();
        checks++; if (instr_pc !== 32'h8 || fault !== 1'b0 || instr !== 32'h113) begin failures++; $display("FAIL resume got=%h/%b/%h want=8/0/113", instr_pc, fault, instr); end
        tick();
        checks++; if (instr_pc !== 32'hC) begin failures++; $display("FAIL resume_next got=%h want=c", instr_pc); end
    endtask

    task automatic test_fault_misaligned();
        redirect = 1'b1; redirect_pc = 32'h6; instr_ready = 1'b0;
        tick();
        redirect = 1'b0;
        tick();
        checks++; if (instr_pc !== 32'h6 || fault !== 1'b1 || instr !== 32'h93) begin failures++; $display("FAIL misalign got=%h/%b/%h want=6/1/93", instr_pc, fault, instr); end
    endtask
`endif

    initial begin
        rst = 1'b1; redirect = 1'b0; redirect_pc = 32'h0; instr_ready = 1'b0;
        test_reset();
        test_stall();
        test_redirect_full();
        test_reset_midstream();
`ifndef IFU_FAULT_CHECK_EN
        test_imem_edge();
        test_pc_wrap();
`else
        test_fault_range();
        test_fault_misaligned();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
